cmd_aggregator: RTL and testbench

Assembles three consecutive bytes from the UART receiver into the 24-bit command word consumed by the command dispatcher. Sits between the UART receiver (`rx_data`/`rx_rdy`/`clr_rx_rdy`) and the dispatcher (`cmd`/`cmd_rdy`/`clr_cmd_rdy`). Holds a completed command until it is cleared, and back-pressures the receiver meanwhile. An optional inter-byte timeout discards stale partial commands.

---
 rtl/cmd_aggregator.sv | 101 ++++++++++
 tb/tb_cmd_aggregator.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cmd_aggregator.sv
// Packs three UART bytes into a 24-bit command word and holds it until the dispatcher clears it.
// Optional inter-byte timeout is compiled in with `define CMD_TIMEOUT_EN.
module cmd_aggregator #(
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_rdy,
   output logic        clr_rx_rdy,
   output logic [23:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   output logic        timeout_err
);

   typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2, FULL} state_t;

   // Handshake: a byte is consumed in any cycle where clr_rx_rdy is high (rx_rdy high, not FULL,
   // not in reset); the command is offered while cmd_rdy is high and retired by clr_cmd_rdy.
   state_t state;
   logic   timeout_hit;

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("cmd_aggregator: TIMEOUT_CYCLES must be at least 2");
   end

   assign clr_rx_rdy = rst_n && rx_rdy && (state != FULL);

`ifdef CMD_TIMEOUT_EN
   localparam int           CW    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] idle_cnt;
   logic          counting;

   assign counting    = ((state == WAIT_B1) || (state == WAIT_B2)) && !rx_rdy;
   assign timeout_hit = counting && (idle_cnt == LIMIT);

   // Any capture, timeout or idle/full state resets the idle count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idle_cnt    <= '0;
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= timeout_hit;
         if (counting && !timeout_hit) idle_cnt <= idle_cnt + 1'b1;
         else                          idle_cnt <= '0;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= WAIT_B0;
         cmd     <= 24'h000000;
         cmd_rdy <= 1'b0;
      end else begin
         case (state)
            WAIT_B0: begin
               if (rx_rdy) begin
                  cmd[23:16] <= rx_data;
                  state      <= WAIT_B1;
               end
            end
            WAIT_B1: begin
               if (rx_rdy) begin
                  cmd[15:8] <= rx_data;
                  state     <= WAIT_B2;
               end else if (timeout_hit) begin
                  state <= WAIT_B0;
               end
            end
            WAIT_B2: begin
               if (rx_rdy) begin
                  cmd[7:0] <= rx_data;
                  cmd_rdy  <= 1'b1;
                  state    <= FULL;
               end else if (timeout_hit) begin
                  state <= WAIT_B0;
               end
            end
            FULL: begin
               // Pending byte stays in the UART until the command is retired.
               if (clr_cmd_rdy) begin
                  cmd_rdy <= 1'b0;
                  state   <= WAIT_B0;
               end
            end
            default: begin
               state   <= WAIT_B0;
               cmd_rdy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cmd_aggregator.sv
// Directed bench for cmd_aggregator; inputs driven on falling edges, outputs sampled #1 later.
module tb_cmd_aggregator;

   localparam int TO = 16;

   logic        clk;
   logic        rst_n;
   logic [7:0]  rx_data;
   logic        rx_rdy;
   logic        clr_rx_rdy;
   logic [23:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy;
   logic        timeout_err;

   int n_cmp  = 0;
   int n_fail = 0;

   cmd_aggregator #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_rdy(rx_rdy),
      .clr_rx_rdy(clr_rx_rdy), .cmd(cmd), .cmd_rdy(cmd_rdy),
      .clr_cmd_rdy(clr_cmd_rdy), .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One UART byte: rx_rdy high until the consuming edge, dropped the cycle after.
   task automatic put(input logic [7:0] b);
      rx_data = b;
      rx_rdy  = 1'b1;
      #1 chk("clr_rx_rdy_on_byte", {23'd0, clr_rx_rdy}, 24'd1);
      tick();
      rx_rdy = 1'b0;
   endtask

   task automatic retire();
      clr_cmd_rdy = 1'b1;
      tick();
      clr_cmd_rdy = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; rx_data = 8'h00; rx_rdy = 1'b0; clr_cmd_rdy = 1'b0;
      @(negedge clk);
      rx_rdy = 1'b1; rx_data = 8'h77;
      tick();
      #1;
      chk("reset_cmd", cmd, 24'h000000);
      chk("reset_cmd_rdy", {23'd0, cmd_rdy}, 24'd0);
      chk("reset_timeout_err", {23'd0, timeout_err}, 24'd0);
      chk("reset_clr_rx_rdy", {23'd0, clr_rx_rdy}, 24'd0);
      @(negedge clk);
      rx_rdy = 1'b0; rst_n = 1'b1;
      tick();

      // Basic assembly
      put(8'h09); put(8'h05);
      #1 chk("cmd_rdy_before_b2", {23'd0, cmd_rdy}, 24'd0);
      put(8'h3C);
      #1;
      chk("cmd_rdy_after_b2", {23'd0, cmd_rdy}, 24'd1);
      chk("cmd_basic", cmd, 24'h09053C);

      // Hold FULL with a pending byte
      @(negedge clk);
      rx_data = 8'hAA; rx_rdy = 1'b1;
      for (int i = 0; i < 20; i++) begin
         #1;
         chk("hold_clr_rx_rdy", {23'd0, clr_rx_rdy}, 24'd0);
         chk("hold_cmd", cmd, 24'h09053C);
         chk("hold_cmd_rdy", {23'd0, cmd_rdy}, 24'd1);
         tick();
      end
      clr_cmd_rdy = 1'b1;
      #1 chk("simul_clr_no_consume", {23'd0, clr_rx_rdy}, 24'd0);
      tick();
      clr_cmd_rdy = 1'b0;
      #1;
      chk("cmd_rdy_after_clear", {23'd0, cmd_rdy}, 24'd0);
      chk("aa_consumed_next_cycle", {23'd0, clr_rx_rdy}, 24'd1);
      tick();
      rx_rdy = 1'b0;
      #1 chk("b0_only_overwrites_top", cmd, 24'hAA053C);
      put(8'h11); put(8'h22);
      #1 chk("cmd_aa", cmd, 24'hAA1122);
      retire();

      // clr_cmd_rdy outside FULL is ignored
      put(8'h08);
      retire();
      #1 chk("clr_in_b1_cmd_rdy", {23'd0, cmd_rdy}, 24'd0);
      put(8'h11); put(8'h22);
      #1;
      chk("cmd_after_ignored_clr", cmd, 24'h081122);
      chk("cmd_rdy_after_ignored_clr", {23'd0, cmd_rdy}, 24'd1);
      retire();

      // Reset mid-command
      put(8'h55); put(8'h66);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      chk("midreset_cmd", cmd, 24'h000000);
      chk("midreset_cmd_rdy", {23'd0, cmd_rdy}, 24'd0);
      chk("midreset_timeout_err", {23'd0, timeout_err}, 24'd0);
      put(8'h02); put(8'h1D); put(8'h00);
      #1;
      chk("cmd_after_reset", cmd, 24'h021D00);
      chk("cmd_rdy_after_reset", {23'd0, cmd_rdy}, 24'd1);
      retire();

      // One byte per cycle burst
      rx_rdy = 1'b1; rx_data = 8'hA1;
      tick(); rx_data = 8'hB2;
      #1 chk("burst_b1_consumed", {23'd0, clr_rx_rdy}, 24'd1);
      tick(); rx_data = 8'hC3;
      tick(); rx_rdy = 1'b0;
      #1;
      chk("burst_cmd", cmd, 24'hA1B2C3);
      chk("burst_cmd_rdy", {23'd0, cmd_rdy}, 24'd1);
      retire();

`ifdef CMD_TIMEOUT_EN
      // Stale partial command discarded after TO idle cycles
      put(8'h01);
      for (int i = 0; i < TO - 1; i++) begin
         #1 chk("no_early_timeout", {23'd0, timeout_err}, 24'd0);
         tick();
      end
      #1 chk("timeout_not_yet", {23'd0, timeout_err}, 24'd0);
      tick();
      #1 chk("timeout_pulse", {23'd0, timeout_err}, 24'd1);
      tick();
      #1 chk("timeout_one_cycle", {23'd0, timeout_err}, 24'd0);
      put(8'h04); put(8'h01); put(8'h00);
      #1;
      chk("cmd_after_timeout", cmd, 24'h040100);
      chk("cmd_rdy_after_timeout", {23'd0, cmd_rdy}, 24'd1);
      chk("no_further_timeout", {23'd0, timeout_err}, 24'd0);
      retire();

      // Byte arriving on the limit cycle wins
      put(8'h07);
      for (int i = 0; i < TO - 1; i++) tick();
      put(8'h08);
      #1 chk("limit_byte_no_timeout", {23'd0, timeout_err}, 24'd0);
      tick();
      #1 chk("limit_byte_no_timeout_late", {23'd0, timeout_err}, 24'd0);
      put(8'h09);
      #1 chk("cmd_limit_byte", cmd, 24'h070809);
      retire();
`else
      // Without the timeout a partial command waits indefinitely
      begin
         logic seen_err;
         seen_err = 1'b0;
         put(8'h01);
         for (int i = 0; i < 10_000; i++) begin
            tick();
            seen_err = seen_err | timeout_err;
         end
         chk("no_timeout_when_disabled", {23'd0, seen_err}, 24'd0);
         chk("still_waiting_cmd_rdy", {23'd0, cmd_rdy}, 24'd0);
         put(8'h02); put(8'h03);
         #1;
         chk("cmd_after_long_idle", cmd, 24'h010203);
         chk("cmd_rdy_after_long_idle", {23'd0, cmd_rdy}, 24'd1);
         retire();
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
